// File: rtl/off_chip_pkg.sv
// Shared definitions for the off-chip 2-bit lane link: beat geometry,
// receive FSM states and the beat-to-bit mapping used by both link ends.
package off_chip_pkg;

  localparam int unsigned LANE_W         = 2;
  localparam int unsigned BEATS_PER_BYTE = 4;

  typedef enum logic [1:0] {S_B0, S_B1, S_B2, S_B3} rx_state_t;

  // Beat k carries {byte[4+k], byte[k]}; returns acc with that beat's bits replaced.
  function automatic logic [7:0] lane_place(input logic [7:0]        acc,
                                            input logic [LANE_W-1:0] sym,
                                            input logic [1:0]        beat);
    logic [7:0] r;
    r              = acc;
    r[{1'b0, beat}] = sym[0];
    r[{1'b1, beat}] = sym[1];
    return r;
  endfunction

  function automatic logic [LANE_W-1:0] lane_symbol(input logic [7:0] data,
                                                    input logic [1:0] beat);
    return {data[{1'b1, beat}], data[{1'b0, beat}]};
  endfunction

endpackage

// File: rtl/off_chip_rx_if.sv
// Lane input, consumer handshake and credit return of the receive endpoint.
interface off_chip_rx_if;
  import off_chip_pkg::*;

  logic [LANE_W-1:0] lane_data;
  logic              lane_valid;
  logic              lane_sof;
  logic [7:0]        data_out;
  logic              valid_out;
  logic              ready;
  logic              credit_ret;

  modport master (output lane_data, lane_valid, lane_sof, ready,
                  input  data_out, valid_out, credit_ret);
  modport slave  (input  lane_data, lane_valid, lane_sof, ready,
                  output data_out, valid_out, credit_ret);
endinterface

// File: rtl/rx_byte_fifo.sv
// Byte buffer for the receive endpoint: memory, wrapping pointers and occupancy.
module rx_byte_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  logic [7:0]          mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rptr];

endmodule

// File: rtl/off_chip_rx.sv
// Receive endpoint: reassembles 4-beat lane frames into bytes, buffers them
// and returns one credit per byte handed to the consumer.
module off_chip_rx
  import off_chip_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  off_chip_rx_if.slave  lnk,
  output logic          err_frame,
  output logic          err_ovf
);

  rx_state_t  state;
  logic [7:0] acc;
  logic [1:0] beat_idx;
  logic [7:0] byte_done;
  logic       complete;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push;

  assign beat_idx  = state;
  assign byte_done = lane_place(acc, lnk.lane_data, beat_idx);
  assign complete  = lnk.lane_valid & ~lnk.lane_sof & (state == S_B3);
  assign pop       = ~empty & lnk.ready;
  // A full buffer still accepts the byte when the head leaves on the same edge.
  assign push      = complete & (~full | pop);
  assign lnk.valid_out = ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_B0;
      acc            <= '0;
      err_frame      <= 1'b0;
      err_ovf        <= 1'b0;
      lnk.credit_ret <= 1'b0;
    end else begin
      lnk.credit_ret <= pop;
      if (complete & full & ~pop) err_ovf <= 1'b1;
      if (lnk.lane_valid) begin
        if (lnk.lane_sof) begin
          if (state != S_B0) err_frame <= 1'b1;
          acc   <= lane_place('0, lnk.lane_data, 2'd0);
          state <= S_B1;
        end else begin
          case (state)
            S_B0: err_frame <= 1'b1;
            S_B1: begin acc <= byte_done; state <= S_B2; end
            S_B2: begin acc <= byte_done; state <= S_B3; end
            S_B3: state <= S_B0;
            default: state <= S_B0;
          endcase
        end
      end
    end
  end

  rx_byte_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (byte_done),
    .pop       (pop),
    .rd_data   (lnk.data_out),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: doc/off_chip_rx.md
# off_chip_rx

Receive-side endpoint of the off-chip 2-bit lane link. It accepts one 2-bit lane symbol per beat and reassembles 4-beat frames into bytes. Reassembled bytes go into an 8-entry buffer, which drains to the on-chip consumer over a valid/ready handshake. One credit pulse per drained byte returns upstream, so the transmitter never has more than DEPTH bytes in flight.

## Interface
- DEPTH, 8, buffer entries (power of two)
- ADDR_WIDTH, 3, log2(DEPTH)
- clk  input  1  clock
- rst  input  1  reset; rst synchronous, active-high; clock clk
- lane_data  input  2  lane symbol; beat k carries {byte[4+k], byte[k]}
- lane_valid  input  1  lane_data valid this cycle
- lane_sof  input  1  start of frame; marks beat 0
- data_out  output  8  head byte of buffer
- valid_out  output  1  data_out valid
- ready  input  1  consumer accepts data_out when valid_out & ready
- credit_ret  output  1  one-cycle pulse per byte popped
- err_frame  output  1  sticky: frame restarted or unexpected beat
- err_ovf  output  1  sticky: byte completed with buffer full and no pop

## Operation
- Beat = cycle with lane_valid=1. Cycles with lane_valid=0 are ignored: the FSM holds state and partial data.
- FSM states: S_B0, S_B1, S_B2, S_B3. Reset state is S_B0.
  - S_B0: a beat with lane_sof=1 captures bits {4,0} and moves to S_B1. A beat with lane_sof=0 is discarded, sets err_frame and stays in S_B0.
  - S_B1/S_B2: a beat with lane_sof=0 captures bits {5,1} or {6,2} and advances.
  - S_B3: a beat with lane_sof=0 captures bits {7,3}, completes the byte, pushes it and returns to S_B0.
  - Any beat with lane_sof=1 in S_B1..S_B3: discard the partial byte, set err_frame, treat the beat as beat 0 and go to S_B1.
- Push happens on the S_B3 beat edge.
  - Not full: write the buffer.
  - Full with a simultaneous pop: write the buffer; occupancy is unchanged.
  - Full without a pop: drop the byte and set err_ovf.
- Pop: valid_out & ready at a clock edge. Advances rptr.
- Occupancy counter: ADDR_WIDTH+1 bits, range 0..DEPTH.
  - Push only: +1. Pop only: -1. Both: unchanged.
- Pointers: ADDR_WIDTH bits, wrap modulo DEPTH.
- valid_out = (occupancy != 0), decoded from the registered count.
- data_out = mem[rptr]. Stable while valid_out & !ready.
- credit_ret = registered (valid_out & ready).
- Error flags clear only on rst.

## Timing
- Reset values: data_out=0, valid_out=0, credit_ret=0, err_frame=0, err_ovf=0, state=S_B0, occupancy=0, pointers=0, buffer contents=0.
- Latency:
  - Byte completed by a beat in cycle N: valid_out=1 and data_out=byte in cycle N+1.
  - Pop in cycle N: credit_ret=1 in cycle N+1 only.
- Back-to-back frames: beat 0 of the next frame may immediately follow beat 3. Sustained rate is 1 byte per 4 cycles.
- Reset mid-frame: the partial byte is lost; buffered bytes are lost; no credit_ret is issued for them. The transmitter reinitialises its credits to DEPTH on the same rst.
- Simultaneous sof-restart and push cannot occur (push needs lane_sof=0).

## Structure
- Shared package off_chip_pkg holds:
  - LANE_W=2 and BEATS_PER_BYTE=4.
  - The FSM state enum {S_B0..S_B3}.
  - The beat-to-bit mapping function (beat k -> bits {4+k, k}), shared with the transmit side.
- Sub-module rx_byte_fifo holds the memory, pointers, occupancy and full/empty logic, with push/pop/full/empty ports. off_chip_rx holds the FSM, byte assembly, error flags and credit register.

## Test plan
- Single frame: beats 01(sof),10,01,10 with ready=1 → data_out=0xA5 and valid_out in the cycle after beat 3. Pop that cycle; credit_ret pulses one cycle later.
- Stalled frame: same 0xA5 beats separated by 3 idle cycles each → same 0xA5; err_frame stays 0.
- Restart: beats 01(sof),10 then frame 00(sof),00,00,11 → single output 0x88; err_frame=1; occupancy=1 before pop.
- Fill/overflow with ready=0: 8 frames 0x00..0x07 → occupancy=8, valid_out=1. A 9th frame 0xFF → err_ovf=1. Then ready=1 drains 0x00..0x07 in order with 8 credit_ret pulses.
- Full with simultaneous pop: buffer full; complete frame 0x3C in the same cycle as a pop → no err_ovf; occupancy stays 8; 0x3C emerges last.
- Reset mid-operation: 3 bytes buffered plus a half frame, assert rst 1 cycle → all outputs 0. A following frame 0x5A emerges correctly.
